// File: rtl/dpll_control_pkg.sv
// Shared types and default widths for the DPLL search controller.
package dpll_control_pkg;

   localparam int DEF_VARS_BITS    = 8;
   localparam int DEF_CLAUSES_BITS = 10;
   localparam int DEF_TABLE_BITS   = 12;

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_BCP_WAIT   = 4'd1,
      ST_IMPLY      = 4'd2,
      ST_DECIDE     = 4'd3,
      ST_BT_POP     = 4'd4,
      ST_BT_FLIP    = 4'd5,
      ST_LOAD_RANGE = 4'd6,
      ST_BCP_RUN    = 4'd7,
      ST_SAT        = 4'd8,
      ST_UNSAT      = 4'd9
   } state_e;

endpackage

// File: rtl/dpll_control_if.sv
// Bundle of BCP core, imply/trace stack, var-state, range table and decider signals.
interface dpll_control_if #(
   parameter int V = 8,
   parameter int C = 10,
   parameter int T = 12
);
   logic         bcp_busy;
   logic         conflict;
   logic [C-1:0] bcp_clause_idx;
   logic         reset_bcp;
   logic         bcp_en;

   logic         empty_imply;
   logic [V-1:0] var_out_imply;
   logic         val_out_imply;
   logic         type_out_imply;
   logic         pop_imply;

   logic         empty_trace;
   logic [V-1:0] var_out_trace;
   logic         val_out_trace;
   logic         type_out_trace;
   logic         pop_trace;
   logic         push_trace;
   logic [V-1:0] var_in_trace;
   logic         val_in_trace;
   logic         type_in_trace;

   logic         write_vs;
   logic [V-1:0] var_in_vs;
   logic         val_in_vs;
   logic         unassign_in_vs;

   logic [T-1:0] start_clause;
   logic [T-1:0] end_clause;
   logic         read_var_start_end;
   logic [V-1:0] var_in_vse;

   logic [V-1:0] var_idx_d;
   logic         val_d;
   logic         read_d;
   logic [V-1:0] dec_idx_d_in;

   logic [V-1:0] dec_idx_ds_out;
   logic         empty_ds;
   logic         push_ds;
   logic         pop_ds;
   logic [V-1:0] dec_idx_ds_in;

   modport master (
      input  bcp_busy, conflict,
      output bcp_clause_idx, reset_bcp, bcp_en,
      input  empty_imply, var_out_imply, val_out_imply, type_out_imply,
      output pop_imply,
      input  empty_trace, var_out_trace, val_out_trace, type_out_trace,
      output pop_trace, push_trace, var_in_trace, val_in_trace, type_in_trace,
      output write_vs, var_in_vs, val_in_vs, unassign_in_vs,
      input  start_clause, end_clause,
      output read_var_start_end, var_in_vse,
      input  var_idx_d, val_d,
      output read_d, dec_idx_d_in,
      input  dec_idx_ds_out, empty_ds,
      output push_ds, pop_ds, dec_idx_ds_in
   );

   modport slave (
      output bcp_busy, conflict,
      input  bcp_clause_idx, reset_bcp, bcp_en,
      output empty_imply, var_out_imply, val_out_imply, type_out_imply,
      input  pop_imply,
      output empty_trace, var_out_trace, val_out_trace, type_out_trace,
      input  pop_trace, push_trace, var_in_trace, val_in_trace, type_in_trace,
      input  write_vs, var_in_vs, val_in_vs, unassign_in_vs,
      output start_clause, end_clause,
      input  read_var_start_end, var_in_vse,
      output var_idx_d, val_d,
      input  read_d, dec_idx_d_in,
      output dec_idx_ds_out, empty_ds,
      input  push_ds, pop_ds, dec_idx_ds_in
   );
endinterface

// File: rtl/dpll_control_clause_walker.sv
// Walks a clause-table range [start, end) one index per step, end exclusive.
module clause_walker #(
   parameter int T = 12,
   parameter int C = 10
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load_i,
   input  logic [T-1:0] start_i,
   input  logic [T-1:0] end_i,
   input  logic         step_i,
   output logic         done_o,
   output logic [C-1:0] idx_o
);

   logic [T-1:0] counter_q, counter_d;
   logic [T-1:0] limit_q, limit_d;

   // A load takes priority; stepping only advances while the range is not exhausted.
   always_comb begin
      counter_d = counter_q;
      limit_d   = limit_q;
      if (load_i) begin
         counter_d = start_i;
         limit_d   = end_i;
      end else if (step_i && !done_o) begin
         counter_d = counter_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         counter_q <= '0;
         limit_q   <= '0;
      end else begin
         counter_q <= counter_d;
         limit_q   <= limit_d;
      end
   end

   assign done_o = (counter_q == limit_q);
   assign idx_o  = C'(counter_q);

endmodule

// File: rtl/dpll_control.sv
// DPLL search controller: BCP sequencing, decisions and chronological backtracking.
// Optional build macro CONTROL_START_GATE_EN holds the controller in IDLE until start.
module dpll_control
   import dpll_control_pkg::*;
#(
   parameter int MAX_VARS_BITS     = DEF_VARS_BITS,
   parameter int MAX_CLAUSES_BITS  = DEF_CLAUSES_BITS,
   parameter int CLAUSE_TABLE_BITS = DEF_TABLE_BITS,
   parameter int NUM_VARS          = 2**MAX_VARS_BITS - 1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   dpll_control_if.master       bus,
   output logic                 sat,
   output logic                 unsat,
   output logic [3:0]           state_out
);

`ifdef CONTROL_START_GATE_EN
   localparam state_e RESET_STATE = ST_IDLE;
`else
   localparam state_e RESET_STATE = ST_BCP_WAIT;
`endif

   localparam logic [MAX_VARS_BITS-1:0] LAST_DEC = MAX_VARS_BITS'(NUM_VARS);

   state_e                     state_q, state_d;
   logic [MAX_VARS_BITS-1:0]   decIdx_q, decIdx_d;
   logic [MAX_VARS_BITS-1:0]   btVar_q, btVar_d;
   logic                       btVal_q, btVal_d;

   logic                       walkLoad;
   logic                       walkStep;
   logic                       walkDone;
   logic [MAX_CLAUSES_BITS-1:0] walkIdx;

   clause_walker #(
      .T(CLAUSE_TABLE_BITS),
      .C(MAX_CLAUSES_BITS)
   ) u_walker (
      .clock  (clock),
      .reset  (reset),
      .load_i (walkLoad),
      .start_i(bus.start_clause),
      .end_i  (bus.end_clause),
      .step_i (walkStep),
      .done_o (walkDone),
      .idx_o  (walkIdx)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= RESET_STATE;
         decIdx_q <= '0;
         btVar_q  <= '0;
         btVal_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         decIdx_q <= decIdx_d;
         btVar_q  <= btVar_d;
         btVal_q  <= btVal_d;
      end
   end

   // While reset is high every strobe is held off except the BCP flush.
   always_comb begin
      state_d                = state_q;
      decIdx_d               = decIdx_q;
      btVar_d                = btVar_q;
      btVal_d                = btVal_q;
      walkLoad               = 1'b0;
      walkStep               = 1'b0;
      bus.reset_bcp          = reset;
      bus.bcp_en             = 1'b0;
      bus.bcp_clause_idx     = walkIdx;
      bus.pop_imply          = 1'b0;
      bus.pop_trace          = 1'b0;
      bus.push_trace         = 1'b0;
      bus.var_in_trace       = '0;
      bus.val_in_trace       = 1'b0;
      bus.type_in_trace      = 1'b0;
      bus.write_vs           = 1'b0;
      bus.var_in_vs          = '0;
      bus.val_in_vs          = 1'b0;
      bus.unassign_in_vs     = 1'b0;
      bus.read_var_start_end = 1'b0;
      bus.var_in_vse         = '0;
      bus.read_d             = 1'b0;
      bus.push_ds            = 1'b0;
      bus.pop_ds             = 1'b0;
      if (!reset) begin
         unique case (state_q)
            ST_IDLE: begin
`ifdef CONTROL_START_GATE_EN
               if (start) state_d = ST_BCP_WAIT;
`else
               state_d = ST_BCP_WAIT;
`endif
            end
            ST_BCP_WAIT: begin
               if (!bus.bcp_busy) begin
                  if (bus.conflict) begin
                     bus.reset_bcp = 1'b1;
                     state_d       = ST_BT_POP;
                  end else if (!bus.empty_imply) begin
                     state_d = ST_IMPLY;
                  end else begin
                     state_d = ST_DECIDE;
                  end
               end
            end
            ST_IMPLY: begin
               bus.pop_imply          = 1'b1;
               bus.write_vs           = 1'b1;
               bus.var_in_vs          = bus.var_out_imply;
               bus.val_in_vs          = bus.val_out_imply;
               bus.push_trace         = 1'b1;
               bus.var_in_trace       = bus.var_out_imply;
               bus.val_in_trace       = bus.val_out_imply;
               bus.type_in_trace      = 1'b1;
               bus.read_var_start_end = 1'b1;
               bus.var_in_vse         = bus.var_out_imply;
               state_d                = ST_LOAD_RANGE;
            end
            ST_DECIDE: begin
               if (decIdx_q == LAST_DEC) begin
                  state_d = ST_SAT;
               end else begin
                  bus.read_d             = 1'b1;
                  bus.write_vs           = 1'b1;
                  bus.var_in_vs          = bus.var_idx_d;
                  bus.val_in_vs          = bus.val_d;
                  bus.push_trace         = 1'b1;
                  bus.var_in_trace       = bus.var_idx_d;
                  bus.val_in_trace       = bus.val_d;
                  bus.push_ds            = 1'b1;
                  bus.read_var_start_end = 1'b1;
                  bus.var_in_vse         = bus.var_idx_d;
                  decIdx_d               = decIdx_q + 1'b1;
                  state_d                = ST_LOAD_RANGE;
               end
            end
            ST_BT_POP: begin
               if (bus.empty_trace) begin
                  state_d = ST_UNSAT;
               end else begin
                  bus.pop_trace      = 1'b1;
                  bus.write_vs       = 1'b1;
                  bus.unassign_in_vs = 1'b1;
                  bus.var_in_vs      = bus.var_out_trace;
                  bus.val_in_vs      = bus.val_out_trace;
                  if (!bus.type_out_trace) begin
                     btVar_d = bus.var_out_trace;
                     btVal_d = bus.val_out_trace;
                     state_d = ST_BT_FLIP;
                  end
               end
            end
            ST_BT_FLIP: begin
               bus.push_trace         = 1'b1;
               bus.var_in_trace       = btVar_q;
               bus.val_in_trace       = ~btVal_q;
               bus.type_in_trace      = 1'b1;
               bus.write_vs           = 1'b1;
               bus.var_in_vs          = btVar_q;
               bus.val_in_vs          = ~btVal_q;
               bus.pop_ds             = 1'b1;
               bus.read_var_start_end = 1'b1;
               bus.var_in_vse         = btVar_q;
               decIdx_d               = bus.dec_idx_ds_out + 1'b1;
               state_d                = ST_LOAD_RANGE;
            end
            ST_LOAD_RANGE: begin
               walkLoad = 1'b1;
               state_d  = ST_BCP_RUN;
            end
            ST_BCP_RUN: begin
               if (walkDone) begin
                  state_d = ST_BCP_WAIT;
               end else begin
                  walkStep   = 1'b1;
                  bus.bcp_en = 1'b1;
               end
            end
            ST_SAT:   state_d = ST_SAT;
            ST_UNSAT: state_d = ST_UNSAT;
            default:  state_d = RESET_STATE;
         endcase
      end
   end

   assign bus.dec_idx_d_in  = decIdx_q;
   assign bus.dec_idx_ds_in = decIdx_q;
   assign sat               = !reset && (state_q == ST_SAT);
   assign unsat             = !reset && (state_q == ST_UNSAT);
   assign state_out         = state_q;

endmodule

// File: tb/tb_dpll_control.sv
// Directed bench for dpll_control in the default build (no start gate).
module tb_dpll_control;
   import dpll_control_pkg::*;

   logic clock;
   logic reset;
   logic start;
   logic sat;
   logic unsat;
   logic [3:0] state_out;

   int testsRun  = 0;
   int failCount = 0;

   dpll_control_if #(.V(8), .C(10), .T(12)) bus ();

   dpll_control #(
      .MAX_VARS_BITS    (8),
      .MAX_CLAUSES_BITS (10),
      .CLAUSE_TABLE_BITS(12),
      .NUM_VARS         (255)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .bus      (bus.master),
      .sat      (sat),
      .unsat    (unsat),
      .state_out(state_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one clock and settle just past the edge before new inputs or checks.
   task automatic applyStimulus();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset               = 1'b1;
      start               = 1'b0;
      bus.bcp_busy        = 1'b1;
      bus.conflict        = 1'b0;
      bus.empty_imply     = 1'b1;
      bus.var_out_imply   = '0;
      bus.val_out_imply   = 1'b0;
      bus.type_out_imply  = 1'b0;
      bus.empty_trace     = 1'b1;
      bus.var_out_trace   = '0;
      bus.val_out_trace   = 1'b0;
      bus.type_out_trace  = 1'b0;
      bus.start_clause    = '0;
      bus.end_clause      = '0;
      bus.var_idx_d       = '0;
      bus.val_d           = 1'b0;
      bus.dec_idx_ds_out  = '0;
      bus.empty_ds        = 1'b1;

      // Reset state
      applyStimulus();
      checkOutput("rst_state", state_out, 32'd1);
      checkOutput("rst_reset_bcp", bus.reset_bcp, 32'd1);
      checkOutput("rst_sat", sat, 32'd0);
      checkOutput("rst_unsat", unsat, 32'd0);
      checkOutput("rst_bcp_en", bus.bcp_en, 32'd0);
      checkOutput("rst_push_trace", bus.push_trace, 32'd0);
      checkOutput("rst_write_vs", bus.write_vs, 32'd0);
      checkOutput("rst_dec_idx", bus.dec_idx_d_in, 32'd0);

      // Decision path
      reset = 1'b0;
      applyStimulus();
      checkOutput("wait_busy_state", state_out, 32'd1);
      checkOutput("wait_busy_reset_bcp", bus.reset_bcp, 32'd0);
      applyStimulus();
      checkOutput("wait_busy_hold", state_out, 32'd1);
      bus.bcp_busy  = 1'b0;
      bus.var_idx_d = 8'd6;
      bus.val_d     = 1'b1;
      #1;
      checkOutput("wait_idle_reset_bcp", bus.reset_bcp, 32'd0);
      applyStimulus();
      checkOutput("dec_state", state_out, 32'd3);
      checkOutput("dec_read_d", bus.read_d, 32'd1);
      checkOutput("dec_push_trace", bus.push_trace, 32'd1);
      checkOutput("dec_type", bus.type_in_trace, 32'd0);
      checkOutput("dec_var_trace", bus.var_in_trace, 32'd6);
      checkOutput("dec_val_trace", bus.val_in_trace, 32'd1);
      checkOutput("dec_push_ds", bus.push_ds, 32'd1);
      checkOutput("dec_ds_in", bus.dec_idx_ds_in, 32'd0);
      checkOutput("dec_write_vs", bus.write_vs, 32'd1);
      checkOutput("dec_unassign", bus.unassign_in_vs, 32'd0);
      checkOutput("dec_vse", bus.var_in_vse, 32'd6);
      checkOutput("dec_read_vse", bus.read_var_start_end, 32'd1);
      bus.start_clause = 12'd0;
      bus.end_clause   = 12'd10;
      applyStimulus();
      checkOutput("load_state", state_out, 32'd6);
      checkOutput("load_dec_idx", bus.dec_idx_d_in, 32'd1);
      checkOutput("load_push_trace", bus.push_trace, 32'd0);
      checkOutput("load_bcp_en", bus.bcp_en, 32'd0);

      // Ten-clause walk
      applyStimulus();
      for (int i = 0; i < 10; i++) begin
         checkOutput("run10_en", bus.bcp_en, 32'd1);
         checkOutput("run10_idx", bus.bcp_clause_idx, i);
         applyStimulus();
      end
      checkOutput("run10_end_en", bus.bcp_en, 32'd0);
      checkOutput("run10_end_state", state_out, 32'd7);
      applyStimulus();
      checkOutput("run10_back_wait", state_out, 32'd1);

      // Implication path
      bus.empty_imply   = 1'b0;
      bus.var_out_imply = 8'd4;
      bus.val_out_imply = 1'b1;
      applyStimulus();
      checkOutput("imp_state", state_out, 32'd2);
      checkOutput("imp_pop", bus.pop_imply, 32'd1);
      checkOutput("imp_write_vs", bus.write_vs, 32'd1);
      checkOutput("imp_var_vs", bus.var_in_vs, 32'd4);
      checkOutput("imp_val_vs", bus.val_in_vs, 32'd1);
      checkOutput("imp_push_trace", bus.push_trace, 32'd1);
      checkOutput("imp_type", bus.type_in_trace, 32'd1);
      checkOutput("imp_vse", bus.var_in_vse, 32'd4);
      checkOutput("imp_read_d", bus.read_d, 32'd0);
      bus.empty_imply  = 1'b1;
      bus.start_clause = 12'd5;
      bus.end_clause   = 12'd5;
      applyStimulus();
      checkOutput("imp_load_state", state_out, 32'd6);
      applyStimulus();
      checkOutput("empty_range_en", bus.bcp_en, 32'd0);
      applyStimulus();
      checkOutput("empty_range_wait", state_out, 32'd1);

      // Conflict and backtrack through a forced entry to a decision
      bus.conflict       = 1'b1;
      #1;
      checkOutput("conf_reset_bcp", bus.reset_bcp, 32'd1);
      bus.empty_trace    = 1'b0;
      bus.var_out_trace  = 8'd9;
      bus.val_out_trace  = 1'b1;
      bus.type_out_trace = 1'b1;
      applyStimulus();
      bus.conflict = 1'b0;
      #1;
      checkOutput("pop1_state", state_out, 32'd4);
      checkOutput("pop1_pop", bus.pop_trace, 32'd1);
      checkOutput("pop1_push", bus.push_trace, 32'd0);
      checkOutput("pop1_unassign", bus.unassign_in_vs, 32'd1);
      checkOutput("pop1_var", bus.var_in_vs, 32'd9);
      applyStimulus();
      checkOutput("pop1_stay", state_out, 32'd4);
      bus.var_out_trace  = 8'd3;
      bus.val_out_trace  = 1'b1;
      bus.type_out_trace = 1'b0;
      #1;
      checkOutput("pop2_pop", bus.pop_trace, 32'd1);
      checkOutput("pop2_write_vs", bus.write_vs, 32'd1);
      checkOutput("pop2_unassign", bus.unassign_in_vs, 32'd1);
      checkOutput("pop2_var", bus.var_in_vs, 32'd3);
      bus.dec_idx_ds_out = 8'd254;
      bus.empty_ds       = 1'b0;
      applyStimulus();
      bus.var_out_trace  = 8'd7;
      bus.val_out_trace  = 1'b0;
      bus.type_out_trace = 1'b1;
      #1;
      checkOutput("flip_state", state_out, 32'd5);
      checkOutput("flip_push", bus.push_trace, 32'd1);
      checkOutput("flip_pop_trace", bus.pop_trace, 32'd0);
      checkOutput("flip_var_trace", bus.var_in_trace, 32'd3);
      checkOutput("flip_val_trace", bus.val_in_trace, 32'd0);
      checkOutput("flip_type", bus.type_in_trace, 32'd1);
      checkOutput("flip_pop_ds", bus.pop_ds, 32'd1);
      checkOutput("flip_write_vs", bus.write_vs, 32'd1);
      checkOutput("flip_var_vs", bus.var_in_vs, 32'd3);
      checkOutput("flip_val_vs", bus.val_in_vs, 32'd0);
      checkOutput("flip_unassign", bus.unassign_in_vs, 32'd0);
      checkOutput("flip_vse", bus.var_in_vse, 32'd3);
      bus.start_clause = 12'd2;
      bus.end_clause   = 12'd4;
      applyStimulus();
      checkOutput("flip_load_state", state_out, 32'd6);
      checkOutput("flip_dec_idx", bus.dec_idx_d_in, 32'd255);
      checkOutput("flip_pop_ds_off", bus.pop_ds, 32'd0);
      applyStimulus();
      checkOutput("run2_idx2", bus.bcp_clause_idx, 32'd2);
      checkOutput("run2_en2", bus.bcp_en, 32'd1);
      applyStimulus();
      checkOutput("run2_idx3", bus.bcp_clause_idx, 32'd3);
      applyStimulus();
      checkOutput("run2_end_en", bus.bcp_en, 32'd0);
      applyStimulus();
      checkOutput("run2_wait", state_out, 32'd1);

      // Every variable decided: SAT
      applyStimulus();
      checkOutput("last_dec_state", state_out, 32'd3);
      checkOutput("last_dec_read_d", bus.read_d, 32'd0);
      checkOutput("last_dec_push_trace", bus.push_trace, 32'd0);
      checkOutput("last_dec_push_ds", bus.push_ds, 32'd0);
      checkOutput("last_dec_write_vs", bus.write_vs, 32'd0);
      applyStimulus();
      checkOutput("sat_state", state_out, 32'd8);
      checkOutput("sat_flag", sat, 32'd1);
      checkOutput("sat_unsat", unsat, 32'd0);
      bus.conflict = 1'b1;
      applyStimulus();
      applyStimulus();
      checkOutput("sat_sticky", sat, 32'd1);
      checkOutput("sat_sticky_state", state_out, 32'd8);

      // Conflict with empty trace: UNSAT
      reset = 1'b1;
      #1;
      checkOutput("rst_sat_clear", sat, 32'd0);
      checkOutput("rst2_reset_bcp", bus.reset_bcp, 32'd1);
      bus.bcp_busy    = 1'b1;
      bus.empty_trace = 1'b1;
      applyStimulus();
      reset = 1'b0;
      applyStimulus();
      checkOutput("u_busy_reset_bcp", bus.reset_bcp, 32'd0);
      checkOutput("u_dec_idx_cleared", bus.dec_idx_d_in, 32'd0);
      bus.bcp_busy = 1'b0;
      #1;
      checkOutput("u_reset_bcp", bus.reset_bcp, 32'd1);
      applyStimulus();
      checkOutput("u_pop_state", state_out, 32'd4);
      checkOutput("u_pop_trace", bus.pop_trace, 32'd0);
      checkOutput("u_pop_write_vs", bus.write_vs, 32'd0);
      checkOutput("u_pop_unsat", unsat, 32'd0);
      applyStimulus();
      checkOutput("unsat_flag", unsat, 32'd1);
      checkOutput("unsat_sat", sat, 32'd0);
      checkOutput("unsat_state", state_out, 32'd9);
      applyStimulus();
      checkOutput("unsat_sticky", unsat, 32'd1);

      // Reset in the middle of a decision
      reset = 1'b1;
      applyStimulus();
      reset        = 1'b0;
      bus.conflict = 1'b0;
      bus.var_idx_d = 8'd12;
      applyStimulus();
      checkOutput("mid_pre_state", state_out, 32'd3);
      checkOutput("mid_pre_read_d", bus.read_d, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("mid_read_d", bus.read_d, 32'd0);
      checkOutput("mid_push_trace", bus.push_trace, 32'd0);
      checkOutput("mid_push_ds", bus.push_ds, 32'd0);
      checkOutput("mid_write_vs", bus.write_vs, 32'd0);
      checkOutput("mid_reset_bcp", bus.reset_bcp, 32'd1);
      applyStimulus();
      checkOutput("mid_after_state", state_out, 32'd1);
      checkOutput("mid_after_dec_idx", bus.dec_idx_d_in, 32'd0);
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
